// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_AW_DEFAULT = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // RUN-state hazard priority: the encoding is the rank, lowest value wins.
  typedef enum logic [1:0] {
    HzMemStall = 2'd0,
    HzBranch   = 2'd1,
    HzLoadUse  = 2'd2,
    HzNone     = 2'd3
  } hz_cause_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID operands and the load in EX.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_use_rs1,
  input  logic              i_use_rs2,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  output logic              o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_use_rs1 && (i_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_use_rs2 && (i_rs2 == i_ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, branch flush, data-memory wait freeze.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEFAULT,
  parameter int unsigned MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] IDrs1_i,
  input  logic [REG_AW-1:0] IDrs2_i,
  input  logic              IDuseRs1_i,
  input  logic              IDuseRs2_i,
  input  logic              IDEXMemRead_i,
  input  logic [REG_AW-1:0] IDEXrd_i,
  input  logic              EXBranchTaken_i,
  input  logic              MemReq_i,
  input  logic              MemReady_i,
  output logic              controlZeroSel_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IFIDFlush_o,
  output logic              PipeFreeze_o,
  output logic              MemTimeout_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  LoadStallCnt_o,
  output logic [CNT_W-1:0]  MemWaitCnt_o
`endif
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(MEM_TIMEOUT);

  hz_state_e r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic r_tmo, w_tmo_next;
  logic w_load_use;
  hz_cause_e w_cause;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .i_rs1         (IDrs1_i),
    .i_rs2         (IDrs2_i),
    .i_use_rs1     (IDuseRs1_i),
    .i_use_rs2     (IDuseRs2_i),
    .i_ex_mem_read (IDEXMemRead_i),
    .i_ex_rd       (IDEXrd_i),
    .o_load_use    (w_load_use)
  );

  always_comb begin
    if (MemReq_i && !MemReady_i) w_cause = HzMemStall;
    else if (EXBranchTaken_i)    w_cause = HzBranch;
    else if (w_load_use)         w_cause = HzLoadUse;
    else                         w_cause = HzNone;
  end

  always_comb begin
    controlZeroSel_o = 1'b0;
    PCWrite_o        = 1'b1;
    IFIDWrite_o      = 1'b1;
    IFIDFlush_o      = 1'b0;
    PipeFreeze_o     = 1'b0;
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_tmo_next       = r_tmo;
    if (!rst_ni) begin
      controlZeroSel_o = 1'b1;
      PCWrite_o        = 1'b0;
      IFIDWrite_o      = 1'b0;
    end else if (r_state == MEM_WAIT) begin
      // Frozen pipeline: branch and load-use are re-evaluated after release.
      PipeFreeze_o = 1'b1;
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      if (MemReady_i) begin
        w_state_next = RUN;
        w_cnt_next   = '0;
      end else if (r_cnt == TMO_MAX) begin
        w_tmo_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end else begin
      unique case (w_cause)
        HzMemStall: begin
          PipeFreeze_o = 1'b1;
          PCWrite_o    = 1'b0;
          IFIDWrite_o  = 1'b0;
          w_state_next = MEM_WAIT;
          w_cnt_next   = CW'(1);
        end
        HzBranch: begin
          IFIDFlush_o      = 1'b1;
          controlZeroSel_o = 1'b1;
        end
        HzLoadUse: begin
          controlZeroSel_o = 1'b1;
          PCWrite_o        = 1'b0;
          IFIDWrite_o      = 1'b0;
        end
        HzNone: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_tmo   <= w_tmo_next;
    end
  end

  assign MemTimeout_o = r_tmo;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_ld_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic w_ld_inc;

  assign w_ld_inc = (r_state == RUN) && (w_cause == HzLoadUse);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ld_cnt   <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_ld_inc)     r_ld_cnt   <= r_ld_cnt + CNT_W'(1);
      if (PipeFreeze_o) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign LoadStallCnt_o = r_ld_cnt;
  assign MemWaitCnt_o   = r_wait_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors queue expected outputs, a monitor checks them.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 5;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] rs1, rs2, ex_rd;
  logic              use1, use2, ex_mr, br, req, rdy;
  logic              czs, pcw, ifidw, flush, freeze, tmo;
`ifdef HAZARD_PERF_EN
  logic [31:0]       ld_cnt, wait_cnt;
`endif

  hazard_ctrl #(
    .REG_AW      (REG_AW),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .IDrs1_i          (rs1),
    .IDrs2_i          (rs2),
    .IDuseRs1_i       (use1),
    .IDuseRs2_i       (use2),
    .IDEXMemRead_i    (ex_mr),
    .IDEXrd_i         (ex_rd),
    .EXBranchTaken_i  (br),
    .MemReq_i         (req),
    .MemReady_i       (rdy),
    .controlZeroSel_o (czs),
    .PCWrite_o        (pcw),
    .IFIDWrite_o      (ifidw),
    .IFIDFlush_o      (flush),
    .PipeFreeze_o     (freeze),
    .MemTimeout_o     (tmo)
`ifdef HAZARD_PERF_EN
    ,
    .LoadStallCnt_o   (ld_cnt),
    .MemWaitCnt_o     (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Expected output bundles: {czs, pcw, ifidw, flush, freeze, tmo}
  localparam logic [5:0] E_RST    = 6'b100000;
  localparam logic [5:0] E_IDLE   = 6'b011000;
  localparam logic [5:0] E_BUBBLE = 6'b100000;
  localparam logic [5:0] E_FLUSH  = 6'b111100;
  localparam logic [5:0] E_FREEZE = 6'b000010;
  localparam logic [5:0] E_FRZTMO = 6'b000011;

  // Monitor: outputs are Mealy, so every driven cycle presents a result at the falling edge.
  initial begin
    exp_t       e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {czs, pcw, ifidw, flush, freeze, tmo};
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got czs/pcw/ifidw/flush/freeze/tmo=%b expected=%b",
                   e.name, got, e.exp);
        end
      end
    end
  end

  task automatic vec(input logic r, input logic [REG_AW-1:0] a, input logic ua,
                     input logic [REG_AW-1:0] b, input logic ub, input logic mr,
                     input logic [REG_AW-1:0] rd, input logic bt, input logic rq,
                     input logic ry, input logic [5:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; rs1 = a; use1 = ua; rs2 = b; use2 = ub;
    ex_mr = mr; ex_rd = rd; br = bt; req = rq; rdy = ry;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; rs1 = '0; rs2 = '0; use1 = 1'b0; use2 = 1'b0;
    ex_mr = 1'b0; ex_rd = '0; br = 1'b0; req = 1'b0; rdy = 1'b0;

    //   rst rs1 u1 rs2 u2 mr rd br rq ry
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST,    "reset");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "idle");
    vec(1, 5, 1, 0, 0, 1, 5, 0, 0, 0, E_BUBBLE, "load_use_rs1");
    vec(1, 5, 1, 0, 0, 0, 5, 0, 0, 0, E_IDLE,   "after_bubble");
    vec(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, E_IDLE,   "rd_x0");
    vec(1, 0, 0, 7, 0, 1, 7, 0, 0, 0, E_IDLE,   "rs2_unused");
    vec(1, 0, 0, 7, 1, 1, 7, 0, 0, 0, E_BUBBLE, "load_use_rs2");
    vec(1, 5, 1, 0, 0, 1, 5, 1, 0, 0, E_FLUSH,  "branch_over_lu");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_IDLE,   "zero_wait");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "wait_enter");
    vec(1, 5, 1, 0, 0, 1, 5, 1, 1, 0, E_FREEZE, "wait_branch_ign");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "wait_3");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_FREEZE, "wait_release");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "run_again");
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    #1;
    checks++;
    if (ld_cnt !== 32'd2) begin
      errors++;
      $display("FAIL perf_load_stall: got=%0d expected=2", ld_cnt);
    end
    checks++;
    if (wait_cnt !== 32'd4) begin
      errors++;
      $display("FAIL perf_mem_wait: got=%0d expected=4", wait_cnt);
    end
`endif
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "tmo_eval1");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "tmo_eval2");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "tmo_eval3");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "tmo_eval4");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FREEZE, "tmo_eval5");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZTMO, "tmo_set");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZTMO, "tmo_sticky");
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RST,    "reset_mid_wait");
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "post_reset");

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
